// File: rtl/i2s_primary_tx.sv
// I2S primary transmitter: 64-bit stereo frames, sck = ck/(2*DIV), samples MSB-first one bit after the ws edge.
// Latency: a pair accepted during frame N is sent in frame N+1. Backpressure: in_ready stays low until the holding register moves into the shift registers at frame start.
// Optional I2S_UNDERRUN_COUNT_EN adds a saturating 16-bit underrun counter with a synchronous clear input.
module i2s_primary_tx #(
    parameter int DIV  = 4,
    parameter int BITS = 16
) (
    input  logic            ck,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] in_left,
    input  logic [BITS-1:0] in_right,
    output logic            sck,
    output logic            ws,
    output logic            sd,
    output logic            en,
    output logic [5:0]      frame_posn,
    output logic            underrun
`ifdef I2S_UNDERRUN_COUNT_EN
    ,
    input  logic            underrun_clr,
    output logic [15:0]     underrun_count
`endif
);

    localparam int CW = $clog2(2 * DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(2 * DIV - 1);
    localparam logic [CW-1:0] CNT_DIV = CW'(DIV);
    localparam logic [5:0] L_FIRST = 6'd1;
    localparam logic [5:0] L_LAST  = 6'(BITS);
    localparam logic [5:0] R_FIRST = 6'd33;
    localparam logic [5:0] R_LAST  = 6'(32 + BITS);

    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic            wrap;
    logic            frame_start;
    logic [5:0]      posn_nxt;
    logic            handshake;
    logic            hold_full;
    logic [BITS-1:0] hold_left;
    logic [BITS-1:0] hold_right;
    logic [BITS-1:0] shift_left;
    logic [BITS-1:0] shift_right;

    assign wrap        = (count == CNT_MAX);
    assign count_nxt   = wrap ? '0 : count + 1'b1;
    assign posn_nxt    = frame_posn + 6'd1;
    assign frame_start = wrap && (frame_posn == 6'd63);
    assign in_ready    = !hold_full;
    assign handshake   = in_valid && in_ready;

    // sck is a register that mirrors the upper half of the divider count.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            count <= CNT_DIV;
            sck   <= 1'b1;
            en    <= 1'b0;
        end else begin
            count <= count_nxt;
            sck   <= (count_nxt >= CNT_DIV);
            en    <= wrap;
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            hold_full  <= 1'b0;
            hold_left  <= '0;
            hold_right <= '0;
        end else if (frame_start && hold_full) begin
            hold_full <= 1'b0;
        end else if (handshake) begin
            hold_left  <= in_left;
            hold_right <= in_right;
            hold_full  <= 1'b1;
        end
    end

    // All serial outputs change together on the sck falling edge.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            frame_posn  <= 6'd63;
            ws          <= 1'b1;
            sd          <= 1'b0;
            underrun    <= 1'b0;
            shift_left  <= '0;
            shift_right <= '0;
        end else begin
            underrun <= frame_start && !hold_full;
            if (wrap) begin
                frame_posn <= posn_nxt;
                ws         <= posn_nxt[5];
                if (frame_start) begin
                    sd          <= 1'b0;
                    shift_left  <= hold_full ? hold_left  : '0;
                    shift_right <= hold_full ? hold_right : '0;
                end else if (posn_nxt >= L_FIRST && posn_nxt <= L_LAST) begin
                    sd         <= shift_left[BITS-1];
                    shift_left <= {shift_left[BITS-2:0], 1'b0};
                end else if (posn_nxt >= R_FIRST && posn_nxt <= R_LAST) begin
                    sd          <= shift_right[BITS-1];
                    shift_right <= {shift_right[BITS-2:0], 1'b0};
                end else begin
                    sd <= 1'b0;
                end
            end
        end
    end

`ifdef I2S_UNDERRUN_COUNT_EN
    // Clear takes priority over a coincident underrun.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            underrun_count <= 16'h0000;
        end else if (underrun_clr) begin
            underrun_count <= 16'h0000;
        end else if (underrun && underrun_count != 16'hFFFF) begin
            underrun_count <= underrun_count + 16'h0001;
        end
    end
`else
`endif

endmodule

// File: tb/tb_i2s_primary_tx.sv
// Directed bench for i2s_primary_tx at DIV=4, BITS=16; counter steps build only with I2S_UNDERRUN_COUNT_EN.
module tb_i2s_primary_tx;
    localparam int DIV  = 4;
    localparam int BITS = 16;

    logic            ck = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [BITS-1:0] in_left = '0;
    logic [BITS-1:0] in_right = '0;
    logic            sck, ws, sd, en, underrun;
    logic [5:0]      frame_posn;
`ifdef I2S_UNDERRUN_COUNT_EN
    logic            underrun_clr = 1'b0;
    logic [15:0]     underrun_count;
`endif

    int errors = 0;
    int checks = 0;

    i2s_primary_tx #(.DIV(DIV), .BITS(BITS)) dut (
        .ck(ck), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_left(in_left), .in_right(in_right), .sck(sck), .ws(ws), .sd(sd),
        .en(en), .frame_posn(frame_posn), .underrun(underrun)
`ifdef I2S_UNDERRUN_COUNT_EN
        , .underrun_clr(underrun_clr), .underrun_count(underrun_count)
`endif
    );

    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_frame(input logic [15:0] l, input logic [15:0] r);
        logic [63:0] f;
        f = '0;
        for (int i = 0; i < 16; i++) begin
            f[1 + i]  = l[15 - i];
            f[33 + i] = r[15 - i];
        end
        return f;
    endfunction

    // Advance to the next en pulse, sampling 1 time unit after each rising edge.
    task automatic fall(input bit offer, output int per, output int hi, output int ur, output int rd);
        per = 0; hi = 0; ur = 0; rd = 0;
        do begin
            if (offer && per == 2 * DIV - 1) in_valid = 1'b1;
            @(posedge ck); #1;
            if (offer) in_valid = 1'b0;
            per++;
            if (sck === 1'b1) hi++;
            if (underrun === 1'b1) ur++;
            if (in_ready === 1'b1) rd++;
        end while (en !== 1'b1 && per < 40);
        chk("en_timeout", {63'd0, en}, 64'd1);
    endtask

    task automatic capture_frame(input int first_per, input bit offer,
                                 output logic [63:0] sdv, output logic [63:0] wsv,
                                 output int urs, output int rdy);
        int per, hi, ur, rd;
        urs = 0; rdy = 0; sdv = '0; wsv = '0;
        for (int p = 0; p < 64; p++) begin
            fall(offer && p == 0, per, hi, ur, rd);
            chk("period", per, (p == 0) ? first_per : 2 * DIV);
            if (p != 0) chk("sck_high", hi, DIV);
            chk("posn", {58'd0, frame_posn}, p);
            sdv[p] = sd;
            wsv[p] = ws;
            urs += ur;
            if (p > 0) rdy += rd;
        end
    endtask

    initial begin
        logic [63:0] sdv, wsv;
        int urs, rdy, per, hi, ur, rd;

        repeat (3) @(negedge ck);
        chk("rst_sck", {63'd0, sck}, 64'd1);
        chk("rst_ws", {63'd0, ws}, 64'd1);
        chk("rst_sd", {63'd0, sd}, 64'd0);
        chk("rst_en", {63'd0, en}, 64'd0);
        chk("rst_posn", {58'd0, frame_posn}, 64'd63);
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_underrun", {63'd0, underrun}, 64'd0);

        // Pair offered before the first frame start.
        rst = 1'b0;
        in_valid = 1'b1; in_left = 16'hA5F0; in_right = 16'h1234;
        @(posedge ck); #1;
        in_valid = 1'b0;
        chk("accept_first", {63'd0, in_ready}, 64'd0);
        capture_frame(DIV - 1, 1'b0, sdv, wsv, urs, rdy);
        chk("f1_sd", sdv, exp_frame(16'hA5F0, 16'h1234));
        chk("f1_ws", wsv, 64'hFFFFFFFF_00000000);
        chk("f1_underrun", urs, 0);

        // Starved frame.
        capture_frame(2 * DIV, 1'b0, sdv, wsv, urs, rdy);
        chk("f2_sd", sdv, 64'd0);
        chk("f2_ws", wsv, 64'hFFFFFFFF_00000000);
        chk("f2_underrun", urs, 1);

        // Handshake exactly in the frame-start cycle with hold empty.
        in_left = 16'h8001; in_right = 16'h7FFE;
        capture_frame(2 * DIV, 1'b1, sdv, wsv, urs, rdy);
        chk("f3_sd", sdv, 64'd0);
        chk("f3_underrun", urs, 1);
        chk("f3_ready_cycles", rdy, 0);
        chk("f3_ready_end", {63'd0, in_ready}, 64'd0);
        in_left = 16'hFFFF; in_right = 16'hFFFF;
        capture_frame(2 * DIV, 1'b0, sdv, wsv, urs, rdy);
        chk("f4_sd", sdv, exp_frame(16'h8001, 16'h7FFE));
        chk("f4_underrun", urs, 0);

        // Load hold mid-frame, then reset at posn 20.
        for (int p = 0; p <= 20; p++) begin
            fall(1'b0, per, hi, ur, rd);
            if (p == 5) begin
                in_valid = 1'b1; in_left = 16'hDEAD; in_right = 16'hBEEF;
                @(posedge ck); #1;
                in_valid = 1'b0;
                chk("mid_accept", {63'd0, in_ready}, 64'd0);
            end
        end
        chk("pre_rst_posn", {58'd0, frame_posn}, 64'd20);
        chk("pre_rst_ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_sck", {63'd0, sck}, 64'd1);
        chk("mid_rst_ws", {63'd0, ws}, 64'd1);
        chk("mid_rst_sd", {63'd0, sd}, 64'd0);
        chk("mid_rst_en", {63'd0, en}, 64'd0);
        chk("mid_rst_posn", {58'd0, frame_posn}, 64'd63);
        chk("mid_rst_ready", {63'd0, in_ready}, 64'd1);
        chk("mid_rst_underrun", {63'd0, underrun}, 64'd0);
        repeat (2) @(negedge ck);
        rst = 1'b0;
        capture_frame(DIV, 1'b0, sdv, wsv, urs, rdy);
        chk("post_rst_sd", sdv, 64'd0);
        chk("post_rst_underrun", urs, 1);

`ifdef I2S_UNDERRUN_COUNT_EN
        capture_frame(2 * DIV, 1'b0, sdv, wsv, urs, rdy);
        capture_frame(2 * DIV, 1'b0, sdv, wsv, urs, rdy);
        #2;
        chk("ucount_3", {48'd0, underrun_count}, 64'd3);
        fall(1'b0, per, hi, ur, rd);
        chk("clr_underrun_seen", {63'd0, underrun}, 64'd1);
        underrun_clr = 1'b1;
        @(posedge ck); #1;
        underrun_clr = 1'b0;
        chk("ucount_clr", {48'd0, underrun_count}, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/i2s_primary_tx.md
I2S_PRIMARY_TX -- requirements
Module: i2s_primary_tx

Interface
REQ-001 SHALL have parameter DIV, default 4, meaning ck cycles per sck half-period; legal range 2..255.
REQ-002 SHALL have parameter BITS, default 16, meaning sample width per channel; legal range 8..31.
REQ-003 SHALL have port ck, input, 1, the only clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, stereo sample pair offered.
REQ-006 SHALL have port in_ready, output, 1, holding register empty.
REQ-007 SHALL have port in_left, input, BITS, left sample, two's complement, MSB first.
REQ-008 SHALL have port in_right, input, BITS, right sample.
REQ-009 SHALL have port sck, output, 1, I2S bit clock.
REQ-010 SHALL have port ws, output, 1, word select: 0 = left, 1 = right.
REQ-011 SHALL have port sd, output, 1, serial data.
REQ-012 SHALL have port en, output, 1, one-ck pulse on each sck falling edge.
REQ-013 SHALL have port frame_posn, output, 6, bit index within the 64-bit frame.
REQ-014 SHALL have port underrun, output, 1, one-ck pulse when a frame starts with no sample pair.

Function
REQ-015 SHALL run divider count 0..2*DIV-1 wrapping to 0; sck is registered and equals 1 when count >= DIV.
REQ-016 SHALL define the sck falling edge as the ck edge where count wraps to 0; in that cycle en = 1 and frame_posn increments mod 64.
REQ-017 SHALL treat frame_posn 63->0 as frame start.
REQ-018 SHALL drive ws = 0 for frame_posn 0..31 and ws = 1 for 32..63, changing only on sck falling edges.
REQ-019 SHALL place left MSB at posn 1 and left bits on posn 1..BITS, right MSB at posn 33 and right bits on posn 33..32+BITS; all other positions drive sd = 0.
REQ-020 SHALL update sd, ws and frame_posn in the same ck as the sck falling edge, so they are stable at the rising edge.
REQ-021 SHALL accept a pair into the holding register when in_valid && in_ready; in_ready = !hold_full, with no combinational path from in_valid.
REQ-022 SHALL at frame start with hold_full copy the holding register to the left/right shift registers and clear hold_full.
REQ-023 SHALL at frame start with hold empty load zeros and pulse underrun for that one ck.
REQ-024 SHALL, when a handshake coincides with frame start and hold was empty, store the pair in hold, transmit zeros this frame, pulse underrun, and send the stored pair next frame.
REQ-025 SHALL hold the pair in the holding register until transferred; in_left and in_right are ignored unless the handshake occurs.

Reset
REQ-026 SHALL on rst asynchronously set count = DIV, sck = 1, ws = 1, sd = 0, en = 0, frame_posn = 63, hold_full = 0 (in_ready = 1), shift registers = 0, underrun = 0.
REQ-027 SHALL produce the first sck falling edge DIV ck after rst deasserts, entering frame_posn 0, which is a frame start.
REQ-028 SHALL on rst mid-frame discard the holding and shift contents; no partial frame resumes.

Configuration
REQ-029 SHALL, when macro I2S_UNDERRUN_COUNT_EN is defined, add output underrun_count, 16 bits: it increments on each underrun pulse, saturates at 16'hFFFF, resets to 0 on rst, and clears synchronously when new input underrun_clr is 1 (clear wins over a coincident increment).
REQ-030 SHALL, when I2S_UNDERRUN_COUNT_EN is undefined, omit the underrun_count and underrun_clr ports and their logic; all other behaviour is identical.

Verification
REQ-031 SHALL check DIV=4 after reset: sck period 8 ck, 50% duty; en pulses every 8 ck; frame_posn cycles 0..63 with frame start every 512 ck.
REQ-032 SHALL check BITS=16, left=16'hA5F0, right=16'h1234 offered before the first frame start: sd reads A5F0 MSB-first on posn 1..16 and 1234 on posn 33..48; zeros elsewhere; ws edges at posn 0 and 32.
REQ-033 SHALL check in_valid held low: every frame start pulses underrun and sd stays 0 throughout.
REQ-034 SHALL check in_valid asserted exactly in the frame-start ck with hold empty: the pair is accepted, underrun pulses, zeros are sent that frame, the pair is sent next frame, and in_ready stays 0 until then.
REQ-035 SHALL check rst asserted at posn 20 with hold full: outputs immediately take reset values, in_ready = 1, and the old pair is never transmitted.
REQ-036 SHALL check with I2S_UNDERRUN_COUNT_EN defined: 3 starved frames give underrun_count = 3; underrun_clr coincident with an underrun gives 0.
